alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 64-bit combinational ALU.
- Splits a WIDTH-bit NOR/XOR/ADD/SUB into NSTAGES = WIDTH/SLICE slice stages; the ripple carry is registered between stages.
- Accepts one operation per cycle through a valid/ready handshake; adds zero and signed-overflow flags.
- Sits between the operand register file and the writeback/result buffer of the datapath.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_slice.sv | 33 +++
 rtl/alu_pipe.sv | 126 ++++++++++++
 tb/tb_alu_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and sizing helpers for the pipelined slice ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_NOR = 2'b00,
    ALU_XOR = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SUB = 2'b11
  } alu_op_t;

  // Pipeline depth: one stage per slice, never fewer than one.
  function automatic int alu_nstages(input int width, input int slice);
    return ((width / slice) < 1) ? 1 : (width / slice);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit NOR/XOR/ADD/SUB with ripple carry in and out.
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  alu_op_t          op,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  logic [SLICE-1:0] b_x;
  logic [SLICE:0]   sum;

  always_comb begin
    b_x  = (op == ALU_SUB) ? ~b : b;
    sum  = {1'b0, a} + {1'b0, b_x} + {{SLICE{1'b0}}, cin};
    s    = '0;
    cout = 1'b0;
    case (op)
      ALU_NOR: s = ~(a | b);
      ALU_XOR: s = a ^ b;
      default: begin
        s    = sum[SLICE-1:0];
        cout = sum[SLICE];
      end
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// WIDTH-bit ALU split into WIDTH/SLICE registered slice stages with a
// valid/ready handshake; carry ripples stage to stage through registers.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int NSTAGES = alu_nstages(WIDTH, SLICE);
  localparam int MSB     = WIDTH - 1;

  logic advance;

  logic             vld_in  [NSTAGES];
  alu_op_t          op_in   [NSTAGES];
  logic [WIDTH-1:0] a_in    [NSTAGES];
  logic [WIDTH-1:0] b_in    [NSTAGES];
  logic [WIDTH-1:0] acc_in  [NSTAGES];
  logic [WIDTH-1:0] acc_nxt [NSTAGES];
  logic             c_in    [NSTAGES];
  logic [SLICE-1:0] s_sl    [NSTAGES];
  logic             c_sl    [NSTAGES];

  logic             vld_p [NSTAGES];
  alu_op_t          op_p  [NSTAGES];
  logic [WIDTH-1:0] a_p   [NSTAGES];
  logic [WIDTH-1:0] b_p   [NSTAGES];
  logic [WIDTH-1:0] acc_p [NSTAGES];
  logic             c_p   [NSTAGES];

  logic [WIDTH-1:0] s_q;
  logic             cout_q, zero_q, ovf_q;
  logic             addsub, bx_msb, ovf_nxt;

  // Every stage, bubbles included, moves only when the output slot frees up.
  assign advance  = !vld_p[NSTAGES-1] || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vld_in[k] = in_valid;
      assign op_in[k]  = alu_op_t'(op);
      assign a_in[k]   = a;
      assign b_in[k]   = b;
      assign c_in[k]   = cin;
      assign acc_in[k] = '0;
    end else begin : g_body
      assign vld_in[k] = vld_p[k-1];
      assign op_in[k]  = op_p[k-1];
      assign a_in[k]   = a_p[k-1];
      assign b_in[k]   = b_p[k-1];
      assign c_in[k]   = c_p[k-1];
      assign acc_in[k] = acc_p[k-1];
    end

    alu_slice #(.SLICE(SLICE)) u_slice (
      .a    (a_in[k][k*SLICE +: SLICE]),
      .b    (b_in[k][k*SLICE +: SLICE]),
      .op   (op_in[k]),
      .cin  (c_in[k]),
      .s    (s_sl[k]),
      .cout (c_sl[k])
    );

    // Bits above the current slice are still zero, so OR inserts the slice.
    assign acc_nxt[k] = acc_in[k] | (WIDTH'(s_sl[k]) << (k * SLICE));
  end

  assign addsub  = (op_in[NSTAGES-1] == ALU_ADD) || (op_in[NSTAGES-1] == ALU_SUB);
  assign bx_msb  = (op_in[NSTAGES-1] == ALU_SUB) ? ~b_in[NSTAGES-1][MSB] : b_in[NSTAGES-1][MSB];
  assign ovf_nxt = addsub && (a_in[NSTAGES-1][MSB] == bx_msb)
                          && (acc_nxt[NSTAGES-1][MSB] != a_in[NSTAGES-1][MSB]);

  // Stage valids and the final output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTAGES; k++) vld_p[k] <= 1'b0;
      s_q    <= '0;
      cout_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < NSTAGES; k++) vld_p[k] <= vld_in[k];
      s_q    <= acc_nxt[NSTAGES-1];
      cout_q <= addsub && c_sl[NSTAGES-1];
      zero_q <= (acc_nxt[NSTAGES-1] == '0);
      ovf_q  <= ovf_nxt;
    end
  end

  // Inter-stage data registers (stages 0 .. NSTAGES-2)
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k < NSTAGES - 1; k++) begin
        op_p[k]  <= op_in[k];
        a_p[k]   <= a_in[k];
        b_p[k]   <= b_in[k];
        acc_p[k] <= acc_nxt[k];
        c_p[k]   <= c_sl[k];
      end
    end
  end

  assign out_valid = vld_p[NSTAGES-1];
  assign s         = s_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed ops, random stream, backpressure,
// mid-flight reset, plus latency/function checks on two other geometries.
module tb_alu_pipe;

  localparam int NST = 4;

  typedef struct packed {
    logic [63:0] s;
    logic        cout;
    logic        zero;
    logic        ovf;
    logic        lat_chk;
    int unsigned acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [63:0] a = '0, b = '0, s;
  logic [1:0]  op = 2'b00;
  logic        cin = 1'b0, cout, zero, ovf;

  logic        sw_valid = 1'b0, sw_cin = 1'b0;
  logic [1:0]  sw_op = 2'b00;
  logic [63:0] w_a = '0, w_b = '0, w_s;
  logic        w_ir, w_ov, w_cout, w_zero, w_ovf;
  logic [31:0] n_a = '0, n_b = '0, n_s;
  logic        n_ir, n_ov, n_cout, n_zero, n_ovf;

  int unsigned checks = 0, errors = 0, cyc = 0;
  exp_t        sb[$];
  exp_t        e_mon;

  always #5 clk = ~clk;

  alu_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .zero(zero), .ovf(ovf)
  );

  alu_pipe #(.WIDTH(64), .SLICE(64)) u_w64 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(w_ir),
    .a(w_a), .b(w_b), .op(sw_op), .cin(sw_cin), .out_valid(w_ov), .out_ready(1'b1),
    .s(w_s), .cout(w_cout), .zero(w_zero), .ovf(w_ovf)
  );

  alu_pipe #(.WIDTH(32), .SLICE(8)) u_n32 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(n_ir),
    .a(n_a), .b(n_b), .op(sw_op), .cin(sw_cin), .out_valid(n_ov), .out_ready(1'b1),
    .s(n_s), .cout(n_cout), .zero(n_zero), .ovf(n_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] sv, input logic c, z, o);
    exp_t e;
    e = '0;
    e.s = sv; e.cout = c; e.zero = z; e.ovf = o;
    return e;
  endfunction

  // Reference: signed 66-bit sum for overflow, unsigned compare for borrow.
  function automatic exp_t model(input logic [63:0] av, bv, input logic [1:0] opv, input logic cv);
    exp_t              e;
    logic signed [65:0] sa, sbv, r;
    logic [64:0]        u;
    e   = '0;
    sa  = $signed({{2{av[63]}}, av});
    sbv = $signed({{2{bv[63]}}, bv});
    r   = '0;
    case (opv)
      2'b00: e.s = ~(av | bv);
      2'b01: e.s = av ^ bv;
      2'b10: begin
        r      = sa + sbv + $signed({65'd0, cv});
        u      = {1'b0, av} + {1'b0, bv} + {64'd0, cv};
        e.s    = r[63:0];
        e.ovf  = (r[64] != r[63]);
        e.cout = u[64];
      end
      default: begin
        r      = sa - sbv - 66'sd1 + $signed({65'd0, cv});
        e.s    = r[63:0];
        e.ovf  = (r[64] != r[63]);
        e.cout = (({1'b0, av} + {64'd0, cv}) > {1'b0, bv});
      end
    endcase
    e.zero = (e.s == 64'd0);
    return e;
  endfunction

  task automatic send(input logic [63:0] av, bv, input logic [1:0] opv, input logic cv,
                      input exp_t ev, input logic lat);
    int n = 0;
    bit done = 1'b0;
    a = av; b = bv; op = opv; cin = cv; in_valid = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk);
      if (in_ready) begin
        ev.lat_chk = lat;
        ev.acc     = cyc + 1;
        sb.push_back(ev);
        done = 1'b1;
      end
      n++;
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] ra [16];
    logic [63:0] rb [16];
    logic [1:0]  rop [16];
    logic        rc [16];
    logic [63:0] ones, sv;
    logic        vv;

    fork
      forever begin @(posedge clk); cyc++; end
      forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
          if (sb.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
          else begin
            e_mon = sb.pop_front();
            chk("s", s, e_mon.s);
            chk("cout", 64'(cout), 64'(e_mon.cout));
            chk("zero", 64'(zero), 64'(e_mon.zero));
            chk("ovf", 64'(ovf), 64'(e_mon.ovf));
            if (e_mon.lat_chk) chk("latency", 64'(cyc - e_mon.acc + 1), 64'(NST));
          end
        end
      end
      begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
      end
    join_none

    ones = '1;
    for (int i = 0; i < 16; i++) begin
      ra[i]  = {$urandom, $urandom};
      rb[i]  = {$urandom, $urandom};
      rop[i] = 2'($urandom_range(3));
      rc[i]  = 1'($urandom_range(1));
    end
    ra[3] = 64'h7FFF_FFFF_FFFF_FFFF; rb[3] = 64'h0000_0000_0000_0001; rop[3] = 2'b10; rc[3] = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_s", s, 64'd0);
    chk("rst_flags", {61'd0, cout, zero, ovf}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed: carry ripple, XOR, subtract overflow, equal subtract, NOR
    send(ones, 64'd1, 2'b10, 1'b0, mk(64'd0, 1'b1, 1'b1, 1'b0), 1'b1);
    send(ones, 64'd1, 2'b01, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0), 1'b1);
    send(64'h8000_0000_0000_0000, 64'd1, 2'b11, 1'b1,
         mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1), 1'b1);
    send(64'd5, 64'd5, 2'b11, 1'b1, mk(64'd0, 1'b1, 1'b1, 1'b0), 1'b1);
    send(64'd0, 64'd0, 2'b00, 1'b1, mk(ones, 1'b0, 1'b0, 1'b0), 1'b1);
    drain();

    // Back-to-back random stream
    for (int i = 0; i < 16; i++) send(ra[i], rb[i], rop[i], rc[i], model(ra[i], rb[i], rop[i], rc[i]), 1'b1);
    drain();

    // Backpressure: stall six cycles while the next op is presented
    for (int i = 0; i < 5; i++) send(rb[i], ra[i], rop[i], rc[i], model(rb[i], ra[i], rop[i], rc[i]), 1'b0);
    out_ready = 1'b0;
    a = rb[5]; b = ra[5]; op = rop[5]; cin = rc[5]; in_valid = 1'b1;
    @(negedge clk);
    sv = s; vv = out_valid;
    chk("bp_out_valid", 64'(vv), 64'd1);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_s", s, sv);
      chk("bp_hold_valid", 64'(out_valid), 64'(vv));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    for (int i = 5; i < 10; i++) send(rb[i], ra[i], rop[i], rc[i], model(rb[i], ra[i], rop[i], rc[i]), 1'b0);
    drain();

    // Reset with three ops in flight
    for (int i = 10; i < 13; i++) send(ra[i], rb[i], rop[i], rc[i], model(ra[i], rb[i], rop[i], rc[i]), 1'b1);
    in_valid = 1'b0; rst = 1'b1;
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_s", s, 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_rst_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(ra[13], rb[13], rop[13], rc[13], model(ra[13], rb[13], rop[13], rc[13]), 1'b1);
    drain();

    // Geometry sweep: 64/64 (latency 1) and 32/8 (latency 4)
    for (int t = 0; t < 2; t++) begin
      sw_op  = (t == 0) ? 2'b00 : 2'b10;
      w_a    = (t == 0) ? 64'd0 : ones;
      w_b    = (t == 0) ? 64'd0 : 64'd1;
      n_a    = (t == 0) ? 32'd0 : 32'hFFFF_FFFF;
      n_b    = (t == 0) ? 32'd0 : 32'd1;
      sw_cin = 1'b0;
      sw_valid = 1'b1;
      @(posedge clk); #1 sw_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        chk("w64_valid", 64'(w_ov), 64'(k == 1));
        chk("n32_valid", 64'(n_ov), 64'(k == 4));
        if (k == 1) begin
          chk("w64_s", w_s, (t == 0) ? ones : 64'd0);
          chk("w64_flags", {60'd0, w_ir, w_cout, w_zero, w_ovf}, {60'd0, 1'b1, t[0], t[0], 1'b0});
        end
        if (k == 4) begin
          chk("n32_s", 64'(n_s), (t == 0) ? 64'h0000_0000_FFFF_FFFF : 64'd0);
          chk("n32_flags", {60'd0, n_ir, n_cout, n_zero, n_ovf}, {60'd0, 1'b1, t[0], t[0], 1'b0});
        end
      end
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
